// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES serial slave front end.
// Frame states, key-size codes, cipher direction and key-length lookup.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RX_MSG,
        ST_RX_KEY,
        ST_WAIT_AES,
        ST_TX,
        ST_DONE
    } state_t;

    localparam logic [1:0] SZ_128 = 2'b00;
    localparam logic [1:0] SZ_192 = 2'b01;
    localparam logic [1:0] SZ_256 = 2'b10;

    localparam logic ENCR = 1'b0;
    localparam logic DECR = 1'b1;

    // Code 2'b11 is treated as a 256-bit key as well.
    function automatic logic [8:0] key_bits(input logic [1:0] sz);
        case (sz)
            SZ_128:  key_bits = 9'd128;
            SZ_192:  key_bits = 9'd192;
            default: key_bits = 9'd256;
        endcase
    endfunction

endpackage

// File: rtl/aes_spi_slave.sv
// Serial slave: shifts in message + key LSB-first, kicks the AES core, shifts the result out.
// Latency: aes_start one cycle after the last key edge; first SOMI bit one cycle after aes_done.
// No backpressure: the master clocks one bit per cycle; CSS release mid-frame aborts.
module aes_spi_slave
    import aes_spi_pkg::*;
#(
    parameter int MSG_W     = 128,
    parameter int KEY_MAX_W = 256,
    parameter int CNT_W     = $clog2(KEY_MAX_W + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 SIMO,
    input  logic                 CSS,
    input  logic                 mode,
    input  logic [1:0]           size,
    output logic                 SOMI,
    output logic [MSG_W-1:0]     aes_msg,
    output logic [KEY_MAX_W-1:0] aes_key,
    output logic                 aes_mode,
    output logic [1:0]           aes_size,
    output logic                 aes_start,
    input  logic                 aes_done,
    input  logic [MSG_W-1:0]     aes_result,
    output logic                 busy,
    output logic                 frame_err
);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [MSG_W-1:0]       tx_sr, tx_nxt;
    logic [MSG_W-1:0]       msg_nxt;
    logic [KEY_MAX_W-1:0]   key_nxt;
    logic [KEY_MAX_W-1:0]   key_ins;
    logic [8:0]             kb_m1;
    logic                   somi_nxt, start_nxt, ferr_nxt, mode_nxt;
    logic [1:0]             size_nxt;
    logic                   abort;

    // Key length comes from the latched size, so mid-frame size changes are harmless.
    assign kb_m1   = key_bits(aes_size) - 9'd1;
    assign key_ins = {{(KEY_MAX_W-1){1'b0}}, SIMO} << kb_m1;
    assign abort   = CSS && (state inside {ST_HDR, ST_RX_MSG, ST_RX_KEY, ST_WAIT_AES, ST_TX});
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        msg_nxt   = aes_msg;
        key_nxt   = aes_key;
        tx_nxt    = tx_sr;
        somi_nxt  = SOMI;
        start_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        mode_nxt  = aes_mode;
        size_nxt  = aes_size;

        if (abort) begin
            state_nxt = ST_IDLE;
            somi_nxt  = 1'b0;
            ferr_nxt  = 1'b1;
            cnt_nxt   = '0;
        end else begin
            case (state)
                // The header edge itself is consumed here; SIMO on it is don't-care.
                ST_IDLE, ST_HDR: begin
                    somi_nxt = 1'b0;
                    if (!CSS) begin
                        mode_nxt  = mode;
                        size_nxt  = size;
                        key_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = ST_RX_MSG;
                    end
                end
                ST_RX_MSG: begin
                    msg_nxt = {SIMO, aes_msg[MSG_W-1:1]};
                    if (cnt == CNT_W'(MSG_W - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_RX_KEY;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_RX_KEY: begin
                    key_nxt = (aes_key >> 1) | key_ins;
                    if (cnt == CNT_W'(kb_m1)) begin
                        cnt_nxt   = '0;
                        start_nxt = 1'b1;
                        state_nxt = ST_WAIT_AES;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_AES: begin
                    somi_nxt = 1'b0;
                    if (aes_done) begin
                        tx_nxt    = aes_result;
                        somi_nxt  = aes_result[0];
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_TX;
                    end
                end
                ST_TX: begin
                    // cnt counts bits already on the wire; tx_sr[0] is the bit currently driven.
                    if (cnt == CNT_W'(MSG_W)) begin
                        somi_nxt  = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        somi_nxt = tx_sr[1];
                        tx_nxt   = tx_sr >> 1;
                        cnt_nxt  = cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (CSS) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            aes_msg   <= '0;
            aes_key   <= '0;
            tx_sr     <= '0;
            SOMI      <= 1'b0;
            aes_start <= 1'b0;
            frame_err <= 1'b0;
            aes_mode  <= ENCR;
            aes_size  <= SZ_128;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            aes_msg   <= msg_nxt;
            aes_key   <= key_nxt;
            tx_sr     <= tx_nxt;
            SOMI      <= somi_nxt;
            aes_start <= start_nxt;
            frame_err <= ferr_nxt;
            aes_mode  <= mode_nxt;
            aes_size  <= size_nxt;
        end
    end

endmodule

// File: tb/tb_aes_spi_slave.sv
// Bench for aes_spi_slave: table of directed frames plus random frames checked against a frame-level model.
module tb_aes_spi_slave;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         SIMO = 1'b0;
    logic         CSS = 1'b1;
    logic         mode = 1'b0;
    logic [1:0]   size = 2'b00;
    logic         aes_done = 1'b0;
    logic [127:0] aes_result = '0;
    logic         SOMI, aes_mode, aes_start, busy, frame_err;
    logic [1:0]   aes_size;
    logic [127:0] aes_msg;
    logic [255:0] aes_key;

    aes_spi_slave dut (
        .clk(clk), .reset_n(reset_n), .SIMO(SIMO), .CSS(CSS), .mode(mode), .size(size),
        .SOMI(SOMI), .aes_msg(aes_msg), .aes_key(aes_key), .aes_mode(aes_mode),
        .aes_size(aes_size), .aes_start(aes_start), .aes_done(aes_done),
        .aes_result(aes_result), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int start_cnt = 0;
    int start_edge = -1;
    int ferr_cnt = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (aes_start === 1'b1) begin
            start_cnt  <= start_cnt + 1;
            start_edge <= cyc;
        end
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    typedef struct {
        logic [1:0]   size;
        logic         mode;
        logic [127:0] msg;
        logic [255:0] key_in;
        logic [127:0] result;
        int           lat;
        int           abort_key;
        bit           abort_wait;
        bit           stray;
        int           rst_bit;
        int           exp_start;
        int           exp_ferr;
        logic [255:0] exp_key;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic int model_kb(input logic [1:0] sz);
        return (sz == 2'b00) ? 128 : (sz == 2'b01) ? 192 : 256;
    endfunction

    function automatic logic [255:0] model_key(input logic [255:0] k, input logic [1:0] sz);
        logic [255:0] one;
        one = 256'd1;
        return k & ((one << model_kb(sz)) - one);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int           kb, hdr, s0, f0;
        bit           somi_bad, aborted, was_reset;
        logic [127:0] rx;
        kb = model_kb(v.size);
        s0 = start_cnt;
        f0 = ferr_cnt;
        somi_bad = 0;
        aborted = 0;
        was_reset = 0;
        rx = '0;

        CSS  = 1'b0;
        mode = v.mode;
        size = v.size;
        SIMO = 1'($urandom);
        tick;
        hdr  = cyc;
        mode = ~v.mode;
        size = ~v.size;
        chk({tag, " busy_in_frame"}, 256'(busy), 256'(1'b1));

        for (int i = 0; i < 128; i++) begin
            SIMO = v.msg[i];
            if (v.stray && i == 10) begin
                aes_done   = 1'b1;
                aes_result = rnd128();
            end else begin
                aes_done = 1'b0;
            end
            tick;
        end
        aes_done = 1'b0;
        chk({tag, " aes_msg"}, 256'(aes_msg), 256'(v.msg));

        for (int j = 0; j < kb; j++) begin
            if (j == v.abort_key) begin
                aborted = 1;
                break;
            end
            SIMO = v.key_in[j];
            tick;
        end

        if (aborted) begin
            CSS  = 1'b1;
            SIMO = 1'b0;
            tick;
            if (SOMI !== 1'b0) somi_bad = 1;
            tick;
        end else begin
            chk({tag, " aes_key"}, aes_key, v.exp_key);
            if (v.abort_wait) begin
                tick;
                tick;
                CSS = 1'b1;
                tick;
                if (SOMI !== 1'b0) somi_bad = 1;
                aes_done   = 1'b1;
                aes_result = v.result;
                tick;
                aes_done = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (SOMI !== 1'b0) somi_bad = 1;
                    tick;
                end
            end else begin
                for (int l = 0; l < v.lat - 1; l++) begin
                    if (SOMI !== 1'b0) somi_bad = 1;
                    tick;
                end
                if (SOMI !== 1'b0) somi_bad = 1;
                aes_done   = 1'b1;
                aes_result = v.result;
                tick;
                aes_done   = 1'b0;
                aes_result = rnd128();
                for (int k = 0; k < 128; k++) begin
                    if (k == v.rst_bit) begin
                        reset_n = 1'b0;
                        #1;
                        chk({tag, " somi_at_reset"}, 256'(SOMI), 256'(1'b0));
                        chk({tag, " busy_at_reset"}, 256'(busy), 256'(1'b0));
                        was_reset = 1;
                        break;
                    end
                    rx[k] = SOMI;
                    if (k < 127) tick;
                end
                if (was_reset) begin
                    CSS = 1'b1;
                    tick;
                    tick;
                    reset_n = 1'b1;
                    tick;
                end else begin
                    tick;
                    chk({tag, " somi_after_tx"}, 256'(SOMI), 256'(1'b0));
                    chk({tag, " result"}, 256'(rx), 256'(v.result));
                    CSS = 1'b1;
                    tick;
                    tick;
                end
            end
        end

        chk({tag, " busy_end"}, 256'(busy), 256'(1'b0));
        chk({tag, " somi_quiet"}, 256'(somi_bad), 256'(1'b0));
        chk({tag, " start_pulses"}, 256'(start_cnt - s0), 256'((v.exp_start >= 0) ? 1 : 0));
        if (v.exp_start >= 0)
            chk({tag, " start_edge"}, 256'(start_edge - hdr), 256'(v.exp_start));
        chk({tag, " frame_err"}, 256'(ferr_cnt - f0), 256'(v.exp_ferr));
        if (was_reset) begin
            chk({tag, " mode_reset"}, 256'(aes_mode), 256'(1'b0));
            chk({tag, " size_reset"}, 256'(aes_size), 256'(2'b00));
            chk({tag, " key_reset"}, aes_key, 256'd0);
        end else begin
            chk({tag, " aes_mode"}, 256'(aes_mode), 256'(v.mode));
            chk({tag, " aes_size"}, 256'(aes_size), 256'(v.size));
        end
    endtask

    vec_t tbl[7];
    vec_t rv;

    localparam logic [127:0] MSG0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RES0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        //             size   mode  msg   key   result lat abk ab_w stray rst  start ferr exp_key
        tbl[0] = '{2'b00, 1'b0, MSG0, K128, RES0, 5, -1, 0, 0, -1, 256, 0, K128};
        tbl[1] = '{2'b10, 1'b1, MSG0, K256, RES0, 5, -1, 0, 0, -1, 384, 0, K256};
        tbl[2] = '{2'b01, 1'b0, MSG0, K192, RES0, 3, -1, 0, 0, -1, 320, 0, K192};
        tbl[3] = '{2'b00, 1'b0, MSG0, K128, RES0, 5, 50, 0, 0, -1,  -1, 1, K128};
        tbl[4] = '{2'b11, 1'b1, RES0, K256, MSG0, 7, -1, 0, 0, -1, 384, 0, K256};
        tbl[5] = '{2'b00, 1'b0, MSG0, K128, RES0, 5, -1, 1, 1, -1, 256, 1, K128};
        tbl[6] = '{2'b00, 1'b1, MSG0, K128, RES0, 5, -1, 0, 0, 60, 256, 0, K128};

        tick;
        tick;
        chk("rst_somi", 256'(SOMI), 256'(1'b0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_start", 256'(aes_start), 256'(1'b0));
        chk("rst_ferr", 256'(frame_err), 256'(1'b0));
        chk("rst_key", aes_key, 256'd0);
        chk("rst_msg", 256'(aes_msg), 256'd0);
        chk("rst_size", 256'(aes_size), 256'(2'b00));
        reset_n = 1'b1;
        tick;
        tick;

        for (int t = 0; t < 7; t++) begin
            run_frame(tbl[t], $sformatf("vec%0d", t));
        end

        for (int r = 0; r < 6; r++) begin
            rv.size       = 2'($urandom_range(0, 3));
            rv.mode       = 1'($urandom);
            rv.msg        = rnd128();
            rv.key_in     = {rnd128(), rnd128()};
            rv.result     = rnd128();
            rv.lat        = int'($urandom_range(1, 20));
            rv.abort_key  = (r == 3) ? int'($urandom_range(1, 127)) : -1;
            rv.abort_wait = 0;
            rv.stray      = 0;
            rv.rst_bit    = -1;
            rv.exp_start  = (rv.abort_key >= 0) ? -1 : 128 + model_kb(rv.size);
            rv.exp_ferr   = (rv.abort_key >= 0) ? 1 : 0;
            rv.exp_key    = model_key(rv.key_in, rv.size);
            run_frame(rv, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_spi_slave.md
# aes_spi_slave

Parametrised SPI-style slave front end for the AES core. Per frame, it:
- receives a message and a key of selectable length LSB-first on `SIMO`;
- issues a one-cycle start to an external AES core and waits for its done;
- returns the result LSB-first on `SOMI`.

Both modes use the same frame format. It replaces the fixed-length slave with a real frame state machine, a start/done handshake, abort on chip-select release and per-frame key sizing.

## Interface
Parameters:
- `MSG_W`, 128: message/result width in bits.
- `KEY_MAX_W`, 256: key register width; must be ≥ 256.
- `CNT_W`, `$clog2(KEY_MAX_W+1)`: bit counter width.

Ports:
- `clk` in 1: single system clock; all sampling and shifting on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `SIMO` in 1: serial data in, LSB-first.
- `CSS` in 1: chip select, active-low; frames data.
- `mode` in 1: 0 = encrypt, 1 = decrypt. Latched at frame header.
- `size` in 2: `00` = 128-bit key, `01` = 192, `10`/`11` = 256. Latched at header.
- `SOMI` out 1: serial data out, registered, LSB-first.
- `aes_msg` out MSG_W: captured message.
- `aes_key` out KEY_MAX_W: captured key, right-justified, upper bits zero.
- `aes_mode` out 1: latched mode.
- `aes_size` out 2: latched size.
- `aes_start` out 1: one-cycle start pulse.
- `aes_done` in 1: result-valid pulse from the core.
- `aes_result` in MSG_W: core output, valid with `aes_done`.
- `busy` out 1: high in every state except IDLE.
- `frame_err` out 1: one-cycle pulse on aborted frame.

## Operation
- States:
  - IDLE → HDR → RX_MSG → RX_KEY → WAIT_AES → TX → DONE → IDLE.
- IDLE:
  - Edge with `CSS`=0 latches `mode`/`size` into `aes_mode`/`aes_size`.
  - Clears `aes_key`, sets counter = 0, goes to RX_MSG.
  - `SIMO` is ignored on this header edge.
- RX_MSG:
  - Each edge: `aes_msg <= {SIMO, aes_msg[MSG_W-1:1]}`, counter +1.
  - After bit MSG_W-1, counter clears and state goes to RX_KEY.
- RX_KEY:
  - Key length KB = 128/192/256 from latched size.
  - Each edge shifts `SIMO` into bit KB-1 of `aes_key`; bits ≥ KB stay zero.
  - After bit KB-1, state goes to WAIT_AES and `aes_start` is registered high for exactly one cycle.
- WAIT_AES:
  - `SOMI` = 0.
  - On an edge with `aes_done`=1: `aes_result` is loaded into the TX shift register, `SOMI <= aes_result[0]`, counter = 1, state goes to TX.
- TX:
  - Each edge drives the next bit on `SOMI`.
  - After MSG_W bits, `SOMI <= 0` and state goes to DONE.
- DONE: holds until `CSS`=1, then goes to IDLE.
- Abort rules:
  - `CSS`=1 sampled in HDR, RX_MSG, RX_KEY, WAIT_AES or TX aborts the frame: state goes to IDLE, `SOMI` = 0, `frame_err` pulses.
  - Abort in WAIT_AES: a later `aes_done` is ignored.
  - `aes_start` is never issued for an incomplete frame.
- `aes_done` outside WAIT_AES is ignored.
- `mode`/`size` changes mid-frame have no effect.
- `aes_msg`/`aes_key` hold their values from WAIT_AES until the next frame's header.

## Timing
- Reset values: state IDLE; `SOMI`, `aes_start`, `busy`, `frame_err`, `aes_mode` = 0; `aes_size` = 00; `aes_msg`, `aes_key`, counter = 0.
- Reset mid-frame: immediate return to IDLE, no `frame_err`.
- With the header at edge 0:
  - message bits are sampled at edges 1..MSG_W;
  - key bits at edges MSG_W+1..MSG_W+KB;
  - `aes_start` is high in the cycle after edge MSG_W+KB.
- Result output:
  - first result bit appears on `SOMI` after the edge that samples `aes_done`;
  - bit i is valid for one full cycle;
  - `SOMI` is 0 after bit MSG_W-1.
- Frame length: 1 + MSG_W + KB edges of input, plus core latency, plus MSG_W output cycles.
- The master keeps `CSS` low throughout.

## Structure
- Shared package `aes_spi_pkg`:
  - state enum;
  - size codes `SZ_128`, `SZ_192`, `SZ_256`;
  - `ENCR`/`DECR` constants;
  - function `key_bits(size)` returning 128/192/256.
- No sub-module needed. The AES core is instantiated by the parent and connected through the `aes_*` ports.

## Test plan
- **128-bit encrypt.** Stimulus:
  - size=00, mode=0;
  - msg `00112233445566778899aabbccddeeff`, key `000102030405060708090a0b0c0d0e0f`;
  - stub core returns `69c4e0d86a7b0430d8cdb78070b4c55a` 5 cycles after start.
  - Required response:
    - `aes_key[255:128]` = 0;
    - `aes_start` high at cycle 257 only;
    - `SOMI` outputs the result LSB-first over 128 cycles, then 0;
    - `busy` is low after `CSS` rises.
- **256-bit decrypt.** Stimulus: size=10, mode=1, key `000102…1f`. Required response:
  - 256 key bits are captured;
  - `aes_start` at cycle 385;
  - `aes_mode`=1, `aes_size`=10.
- **192-bit key, size=01.** Required response:
  - `aes_key[191:0]` = `000102…17`;
  - `aes_key[255:192]` = 0;
  - `aes_start` at cycle 321.
- **Abort during key.** Stimulus: `CSS` raised after 50 key bits. Required response:
  - `frame_err` pulses once;
  - `aes_start` never asserts;
  - the next full frame completes correctly.
- **Stray done.** Stimulus: `aes_done` pulsed during RX_MSG, then abort in WAIT_AES, then late `aes_done`. Required response: both `aes_done` pulses are ignored and `SOMI` stays 0.
- **Reset mid-TX.** Stimulus: `reset_n` low at result bit 60. Required response: `SOMI` = 0 and `busy` = 0 immediately, with no `frame_err`.
